alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Pipelined ALU that serves as the design under test for the ALU verification environment.
//  Upstream, the driver presents operand/opcode transactions on a valid/ready input port.
//  Downstream, the monitor/scoreboard takes results and flags from a valid/ready output port.
//  Fixed 2-stage pipeline: S1 registers the operands, S2 registers the computed result.
//  Full backpressure; no transaction is ever lost or duplicated.
// PARAMETERS
//  WIDTH      8   operand/result width in bits (legal 4..32)
//  OPW        4   opcode width; only codes defined in alu_pkg are legal
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous assert, active-low reset
//  in_valid   in   1      upstream has a transaction
//  in_ready   out  1      block accepts the transaction this cycle
//  in_op      in   OPW    opcode (alu_pkg::alu_op_e)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  out_valid  out  1      result is valid
//  out_ready  in   1      downstream takes the result this cycle
//  out_res    out  WIDTH  result
//  out_flags  out  4      {illegal, ovf, carry, zero} (alu_pkg::alu_flags_t)
// BEHAVIOUR
//  - Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_res=0, out_flags=0.
//    in_ready is 1 from the first cycle after release.
//    Any in-flight transaction is discarded, including a mid-stall one.
//  - Handshakes:
//    - Transfer occurs when valid&&ready at a rising edge.
//    - Valid must not depend on ready.
//    - Held data stays stable while valid && !ready.
//  - Pipeline:
//    - s2_adv = !s2_valid || out_ready
//    - s1_adv = !s1_valid || s2_adv
//    - in_ready = s1_adv (combinational from out_ready; no skid buffer)
//    - Latency is 2 cycles, accept edge to out_valid, with out_ready held high.
//    - Throughput is 1 transaction per cycle.
//  - Stall: when out_ready=0 with both stages full, in_ready=0 and both stages hold.
//  - Simultaneous pop and push in the same cycle with a full pipe: both occur; no bubble.
//  - Opcodes, all modulo 2^WIDTH:
//    - ADD 0: a+b. carry = bit WIDTH of the sum. ovf = signed overflow.
//    - SUB 1: a-b. carry = borrow (a<b unsigned). ovf = signed overflow.
//    - AND 2, OR 3, XOR 4: bitwise. carry=0, ovf=0.
//    - SHL 5, SHR 6: shift by b[$clog2(WIDTH)-1:0]. carry = last bit shifted out (0 if amount is 0). SHR is logical.
//    - CMP 7: res = {'0, a<b signed}. carry = a<b unsigned.
//  - zero = (res==0) for every legal opcode.
//  - Illegal opcode: res=0, flags={1,0,0,0}. The transaction still flows through the pipe.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   - Opcode MUL 8 is legal: res = low WIDTH bits of a*b (unsigned).
//   - ovf = 1 if the high WIDTH bits are nonzero. carry=0.
//   - The product is registered in S2. Latency is unchanged.
//  ALU_MUL_EN undefined:
//   - Opcode 8 is illegal (illegal flag set).
//   - No multiplier is synthesised.
// STRUCTURE
//  alu_pkg holds:
//   - alu_op_e enum (ADD..CMP, MUL)
//   - alu_flags_t packed struct {illegal, ovf, carry, zero}
//   - the OPW localparam
//   - function is_legal_op(op), which honours ALU_MUL_EN
//  Sub-module alu_core: purely combinational {op,a,b} -> {res,flags}. It sits between S1 and S2.
//  alu_pipe owns all registers and the handshake logic.
// TESTING (WIDTH=8)
//  1. ADD a=8'hFF b=8'h01, out_ready=1 -> res 8'h00, flags carry=1 zero=1 ovf=0. out_valid exactly 2 cycles after accept.
//  2. SUB a=8'h80 b=8'h01 -> res 8'h7F, ovf=1, carry=0. CMP a=8'hFF b=8'h01 -> res 1, carry=0.
//  3. Stream 16 back-to-back ADD ops with out_ready toggling 1,0,0,1...:
//     - Results arrive in order, none dropped or duplicated.
//     - in_ready=0 only while both stages are full.
//  4. SHL a=8'h81 b=1 -> res 8'h02, carry=1. SHR a=8'h01 b=1 -> res 0, carry=1, zero=1.
//  5. Opcode 4'hF -> res 0, illegal=1.
//     Opcode 8 with ALU_MUL_EN: a=16 b=16 -> res 0, ovf=1. Without ALU_MUL_EN: illegal=1.
//  6. Assert rst_n=0 with 2 transactions in flight and out_ready=0:
//     - out_valid drops immediately.
//     - After release, no stale result appears.
//     - The first new ADD 3+4 returns 7.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : alu_pkg                                                    |
// | Shared types for the pipelined ALU: opcode enum, flag struct, opcode |
// | width and the opcode legality check.                                 |
// | Config  : ALU_MUL_EN -- when defined, opcode MUL (8) is legal.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_CMP = 4'd7,
    OP_MUL = 4'd8
  } alu_op_e;

  // Bit order matters: packs to {illegal, ovf, carry, zero}, illegal is the MSB.
  typedef struct packed {
    logic illegal;
    logic ovf;
    logic carry;
    logic zero;
  } alu_flags_t;

  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    logic legal;
    legal = (op <= OP_CMP);
`ifdef ALU_MUL_EN
    if (op == OP_MUL) begin
      legal = 1'b1;
    end
`endif
    return legal;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_core                                                   |
// | Purely combinational ALU datapath: {op, a, b} -> {res, flags}.       |
// | Ports   : op    in  OPW    opcode (alu_op_e encoding)                |
// |           a, b  in  WIDTH  operands                                  |
// |           res   out WIDTH  result                                    |
// |           flags out 4      {illegal, ovf, carry, zero}               |
// | Config  : ALU_MUL_EN -- adds the unsigned low-half multiplier.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output alu_flags_t       flags
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SHW-1:0] shamt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] shl_ext;
  logic [WIDTH:0] shr_ext;
  logic           carry;
  logic           ovf;
  logic           illegal;

  assign shamt = b[SHW-1:0];

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = a * b;
`endif

  always_comb begin
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    // The borrow falls out as the extra MSB of the widened difference.
    diff    = {1'b0, a} - {1'b0, b};
    // One guard bit on the outgoing side catches the last bit shifted out;
    // with a zero shift amount the guard bit stays 0.
    shl_ext = {1'b0, a} << shamt;
    shr_ext = {a, 1'b0} >> shamt;

    if (!is_legal_op(op)) begin
      illegal = 1'b1;
    end else begin
      case (op)
        OP_ADD: begin
          res   = sum[WIDTH-1:0];
          carry = sum[WIDTH];
          ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          res   = diff[WIDTH-1:0];
          carry = diff[WIDTH];
          ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
        OP_AND: res = a & b;
        OP_OR:  res = a | b;
        OP_XOR: res = a ^ b;
        OP_SHL: begin
          res   = shl_ext[WIDTH-1:0];
          carry = shl_ext[WIDTH];
        end
        OP_SHR: begin
          res   = shr_ext[WIDTH:1];
          carry = shr_ext[0];
        end
        OP_CMP: begin
          res   = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          carry = (a < b);
        end
`ifdef ALU_MUL_EN
        OP_MUL: begin
          res = prod[WIDTH-1:0];
          ovf = |prod[2*WIDTH-1:WIDTH];
        end
`endif
        default: illegal = 1'b1;
      endcase
    end

    flags.illegal = illegal;
    flags.ovf     = ovf;
    flags.carry   = carry;
    flags.zero    = !illegal && (res == '0);
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_pipe                                                   |
// | Two-stage pipelined ALU with valid/ready on both sides and full      |
// | backpressure. S1 registers the operands, S2 registers the result.    |
// | Ports   : clk, rst_n (async, active-low)                             |
// |           in_valid/in_ready, in_op[OPW], in_a/in_b[WIDTH]  upstream  |
// |           out_valid/out_ready, out_res[WIDTH], out_flags[4] downstr. |
// | Config  : ALU_MUL_EN -- enables opcode MUL (product lands in S2).    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = alu_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output alu_flags_t       out_flags
);

  logic             s1_valid;
  logic [OPW-1:0]   s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_res;
  alu_flags_t       s2_flags;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;

  // A stage may load when it is empty or its contents move on this edge.
  // in_ready is therefore a combinational path from out_ready; there is no
  // skid buffer, so a full pipe with a pop still accepts a push.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= in_op;
        s1_a  <= in_a;
        s1_b  <= in_b;
      end
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op    (s1_op),
    .a     (s1_a),
    .b     (s1_b),
    .res   (core_res),
    .flags (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_flags <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res   <= core_res;
        s2_flags <= core_flags;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_res   = s2_res;
  assign out_flags = s2_flags;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_alu_pipe                                                |
// | Self-checking bench for alu_pipe (WIDTH=8) with a result scoreboard. |
// | Config  : ALU_MUL_EN -- must match the RTL build.                    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_alu_pipe;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic [3:0] out_flags;

  stim_t       stim_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];

  int   n_vec  = 0;
  int   n_fail = 0;
  int   occ    = 0;
  int   smp_occ;
  logic smp_in_ready;
  logic smp_out_ready;

  always #5 clk = ~clk;

  alu_pipe #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  // Reference model: {res[7:0], illegal, ovf, carry, zero}
  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, r, n;
    logic c, v, il;
    logic [7:0] res;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = 0; c = 1'b0; v = 1'b0; il = 1'b0;
    n = ub % 8;
    case (op)
      4'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: begin r = ua << n; c = (n != 0) && (((ua >> (8 - n)) & 1) == 1); end
      4'd6: begin r = ua >> n; c = (n != 0) && (((ua >> (n - 1)) & 1) == 1); end
      4'd7: begin r = (sa < sb) ? 1 : 0; c = (ua < ub); end
`ifdef ALU_MUL_EN
      4'd8: begin r = ua * ub; v = (r > 255); end
`endif
      default: il = 1'b1;
    endcase
    res = r[7:0];
    if (il) return {8'h00, 4'b1000};
    return {res, 1'b0, v, c, (res == 8'h00)};
  endfunction

  // One clock: present the head of stim_q, record handshakes at the negedge.
  task automatic tick();
    if (stim_q.size() > 0) begin
      in_valid = 1'b1;
      in_op    = stim_q[0].op;
      in_a     = stim_q[0].a;
      in_b     = stim_q[0].b;
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    smp_in_ready  = in_ready;
    smp_out_ready = out_ready;
    smp_occ       = occ;
    if (out_valid && out_ready) begin
      got_q.push_back({out_res, out_flags});
      occ--;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_op, in_a, in_b));
      void'(stim_q.pop_front());
      occ++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output bit to, output int cyc);
    cyc = 0;
    while ((stim_q.size() > 0 || got_q.size() < exp_q.size()) && cyc < budget) begin
      tick();
      cyc++;
    end
    to = (stim_q.size() > 0 || got_q.size() < exp_q.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_res !== 8'h00) begin n_fail++; $display("FAIL rst_out_res: got %h want 00", out_res); end
    n_vec++; if (out_flags !== 4'h0) begin n_fail++; $display("FAIL rst_out_flags: got %b want 0000", out_flags); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_latency();
    bit to; int cyc; logic [11:0] e, g;
    out_ready = 1'b1;
    stim_q.push_back({4'd0, 8'hFF, 8'h01});
    tick();
    n_vec++; if (exp_q.size() != 1) begin n_fail++; $display("FAIL add_accept: accepted %0d want 1", exp_q.size()); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_lat_early: out_valid %b want 0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_lat_due: out_valid %b want 1", out_valid); end
    n_vec++; if ({out_res, out_flags} !== 12'h003) begin n_fail++; $display("FAIL add_ff_01: got %h want 003", {out_res, out_flags}); end
    drain(20, to, cyc);
    n_vec++; if (to) begin n_fail++; $display("FAIL add_timeout: got timeout want drained"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL add_sb: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL add_sb: got %h want %h", g, e); end end
    end
    n_vec++; if (got_q.size() != 0) begin n_fail++; $display("FAIL add_extra: got %0d extra want 0", got_q.size()); end
  endtask

  task automatic test_arith();
    bit to; int cyc; logic [11:0] e, g;
    out_ready = 1'b1;
    stim_q.push_back({4'd1, 8'h80, 8'h01});
    stim_q.push_back({4'd7, 8'hFF, 8'h01});
    for (int i = 0; i < 24; i++) begin
      stim_q.push_back({4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom)});
    end
    stim_q.push_back({4'd2, 8'hF0, 8'h3C});
    stim_q.push_back({4'd3, 8'h00, 8'h00});
    stim_q.push_back({4'd4, 8'hA5, 8'hA5});
    drain(100, to, cyc);
    n_vec++; if (to) begin n_fail++; $display("FAIL arith_timeout: got timeout want drained"); end
    n_vec++; if (got_q.size() < 2 || got_q[0] !== 12'h7F4) begin n_fail++; $display("FAIL sub_80_01: got %h want 7F4", (got_q.size() > 0) ? got_q[0] : 12'hxxx); end
    n_vec++; if (got_q.size() < 2 || got_q[1] !== 12'h010) begin n_fail++; $display("FAIL cmp_ff_01: got %h want 010", (got_q.size() > 1) ? got_q[1] : 12'hxxx); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL arith_sb: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL arith_sb: got %h want %h", g, e); end end
    end
    n_vec++; if (got_q.size() != 0) begin n_fail++; $display("FAIL arith_extra: got %0d extra want 0", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit to; int cyc; int k; logic [11:0] e, g; logic [3:0] pat; logic exp_rdy;
    pat = 4'b1001;
    for (int i = 0; i < 16; i++) stim_q.push_back({4'd0, 8'(i * 17), 8'(i + 1)});
    k = 0;
    while (got_q.size() < 16 && k < 300) begin
      out_ready = pat[3 - (k % 4)];
      tick();
      exp_rdy = !(smp_occ == 2 && !smp_out_ready);
      n_vec++;
      if (smp_in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b want %b", k, smp_in_ready, exp_rdy); end
      k++;
    end
    n_vec++; if (got_q.size() != 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL b2b_sb: got %h want %h", g, e); end end
    end
    n_vec++; if (got_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra want 0", got_q.size()); end
    // Full-rate stream: N transactions need N+2 cycles.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) stim_q.push_back({4'd0, 8'(i), 8'(3 * i)});
    drain(50, to, cyc);
    n_vec++; if (to || cyc != 10) begin n_fail++; $display("FAIL b2b_throughput: got %0d cycles want 10", cyc); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL b2b_full_sb: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL b2b_full_sb: got %h want %h", g, e); end end
    end
  endtask

  task automatic test_shift();
    bit to; int cyc;
    logic [11:0] want [4];
    want[0] = 12'h022; want[1] = 12'h003; want[2] = 12'h5A0; want[3] = 12'h010;
    out_ready = 1'b1;
    stim_q.push_back({4'd5, 8'h81, 8'h01});
    stim_q.push_back({4'd6, 8'h01, 8'h01});
    stim_q.push_back({4'd5, 8'h5A, 8'h00});
    stim_q.push_back({4'd6, 8'h80, 8'h07});
    drain(30, to, cyc);
    n_vec++; if (to) begin n_fail++; $display("FAIL shift_timeout: got timeout want drained"); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL shift_%0d: got none want %h", i, want[i]); end
      else if (got_q[0] !== want[i] || exp_q[0] !== want[i]) begin
        n_fail++; $display("FAIL shift_%0d: got %h want %h", i, got_q[0], want[i]);
      end
      if (got_q.size() > 0) void'(got_q.pop_front());
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_illegal();
    bit to; int cyc; logic [11:0] mul_want;
`ifdef ALU_MUL_EN
    mul_want = 12'h005;
`else
    mul_want = 12'h008;
`endif
    out_ready = 1'b1;
    stim_q.push_back({4'hF, 8'h12, 8'h34});
    stim_q.push_back({4'd8, 8'h10, 8'h10});
    drain(30, to, cyc);
    n_vec++; if (to) begin n_fail++; $display("FAIL illegal_timeout: got timeout want drained"); end
    n_vec++; if (got_q.size() < 1 || got_q[0] !== 12'h008) begin n_fail++; $display("FAIL illegal_opF: got %h want 008", (got_q.size() > 0) ? got_q[0] : 12'hxxx); end
    n_vec++; if (got_q.size() < 2 || got_q[1] !== mul_want) begin n_fail++; $display("FAIL op8_16x16: got %h want %h", (got_q.size() > 1) ? got_q[1] : 12'hxxx, mul_want); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_inflight();
    bit to; int cyc; logic [11:0] e, g;
    out_ready = 1'b0;
    stim_q.push_back({4'd0, 8'h11, 8'h22});
    stim_q.push_back({4'd1, 8'h33, 8'h01});
    tick();
    tick();
    n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL inflight_full: got valid %b ready %b want 1 0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_async: out_valid %b want 0", out_valid); end
    stim_q.delete(); exp_q.delete(); got_q.delete(); occ = 0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_stale cyc %0d: out_valid %b want 0", i, out_valid); end
    end
    stim_q.push_back({4'd0, 8'h03, 8'h04});
    drain(20, to, cyc);
    n_vec++; if (to) begin n_fail++; $display("FAIL inflight_timeout: got timeout want drained"); end
    n_vec++; if (got_q.size() != 1 || got_q[0] !== 12'h070) begin n_fail++; $display("FAIL inflight_add_3_4: got %h (n=%0d) want 070", (got_q.size() > 0) ? got_q[0] : 12'hxxx, got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL inflight_sb: got none want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL inflight_sb: got %h want %h", g, e); end end
    end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_arith();
    test_back_to_back();
    test_shift();
    test_illegal();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_alu_pipe
`default_nettype wire
